laser_frame_sched: RTL and testbench

- Front-end scheduler for the two-circle laser coverage engine.
- Accepts 40-point frames from two independent requesters (S0, S1), with frame-level round-robin arbitration.
- Buffers each granted frame completely, then streams it to the engine on NPTS consecutive cycles, because the engine cannot tolerate gaps.
- Waits for the engine's done pulse under a watchdog, then returns the circle centres to the requester with a valid/ready handshake.

---
 rtl/laser_pkg.sv | 43 ++++
 rtl/laser_pt_buf.sv | 40 ++++
 rtl/laser_frame_sched.sv | 180 ++++++++++++++++++
 tb/tb_laser_frame_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared definitions for the laser frame scheduler.
//   NPTS / CW : points per frame and coordinate width
//   PW        : width of the point index counter
//   state_t   : scheduler FSM states (also exported on dbg_state)
//   pt_t      : one point {x, y}
//   res_t     : one result {c1x, c1y, c2x, c2y}
//
// Handshake rule used on every valid/ready pair in this block: a transfer
// happens on the rising CLK edge where valid and ready are both high; the
// sender keeps valid and data stable until that edge, and ready may change
// freely while valid is low.
package laser_pkg;

  localparam int NPTS = 40;
  localparam int CW   = 4;
  localparam int PW   = $clog2(NPTS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pt_t;

  typedef struct packed {
    logic [CW-1:0] c1x;
    logic [CW-1:0] c1y;
    logic [CW-1:0] c2x;
    logic [CW-1:0] c2y;
  } res_t;

  // Point index increment that wraps back to 0 after the last point.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NPTS - 1)) ? '0 : v + PW'(1);
  endfunction

endpackage

// File: rtl/laser_pt_buf.sv
// Frame buffer: NPTS entries of one packed point {x, y}.
//   CLK, RST : clock, asynchronous active-high reset (read register only)
//   wr_en    : write wr_pt into entry wr_idx on the rising edge
//   rd_en    : load entry rd_idx into rd_pt on the rising edge
//   rd_pt    : registered read data; forced to 0 whenever rd_en is low so the
//              engine bus is quiet outside the streaming window
module laser_pt_buf
  import laser_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [PW-1:0]   wr_idx,
  input  logic [2*CW-1:0] wr_pt,
  input  logic            rd_en,
  input  logic [PW-1:0]   rd_idx,
  output logic [2*CW-1:0] rd_pt
);

  // Storage holds no reset: a new frame always overwrites every entry
  // before it is streamed.
  logic [2*CW-1:0] mem [NPTS];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_pt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pt <= '0;
    end else if (rd_en) begin
      rd_pt <= mem[rd_idx];
    end else begin
      rd_pt <= '0;
    end
  end

endmodule

// File: rtl/laser_frame_sched.sv
// Front-end scheduler for the two-circle laser coverage engine.
// Collects a full NPTS-point frame from one of two requesters (frame-level
// round robin), streams it gap-free to the engine, waits for the engine under
// a watchdog, and hands the circle centres back with valid/ready.
//   CLK, RST                 : clock, asynchronous active-high reset
//   s0_* / s1_*              : point input ports (valid/ready, x, y)
//   eng_load, eng_x, eng_y   : point stream, NPTS consecutive cycles per frame
//   eng_done, eng_c*         : engine completion pulse and centres
//   eng_abort                : one-cycle pulse when the watchdog expires
//   res_*                    : result port (valid/ready, src, timeout, centres)
//   dbg_state                : current FSM state (state_t encoding)
// TIMEOUT must be below 2**TOW.
module laser_frame_sched
  import laser_pkg::*;
#(
  parameter int TIMEOUT = 30000,
  parameter int TOW     = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [CW-1:0] s0_x,
  input  logic [CW-1:0] s0_y,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [CW-1:0] s1_x,
  input  logic [CW-1:0] s1_y,
  output logic          eng_load,
  output logic [CW-1:0] eng_x,
  output logic [CW-1:0] eng_y,
  input  logic          eng_done,
  input  logic [CW-1:0] eng_c1x,
  input  logic [CW-1:0] eng_c1y,
  input  logic [CW-1:0] eng_c2x,
  input  logic [CW-1:0] eng_c2y,
  output logic          eng_abort,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_src,
  output logic          res_timeout,
  output logic [CW-1:0] res_c1x,
  output logic [CW-1:0] res_c1y,
  output logic [CW-1:0] res_c2x,
  output logic [CW-1:0] res_c2y,
  output logic [2:0]    dbg_state
);

  state_t          state, state_nx;
  logic            gsel, gsel_nx;
  logic            last_grant;
  logic [PW-1:0]   pt_cnt;
  logic [TOW-1:0]  wd_cnt;
  logic            last_pt;
  logic            fill_hs;
  logic            expire;
  logic [2*CW-1:0] wr_pt;
  logic [2*CW-1:0] rd_pt;
  pt_t             rd_s;
  res_t            res_q;

  assign last_pt   = (pt_cnt == PW'(NPTS - 1));
  assign dbg_state = state;

  // Next state, grant and point-port readies.
  always_comb begin
    state_nx = state;
    gsel_nx  = gsel;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    fill_hs  = 1'b0;
    expire   = 1'b0;
    wr_pt    = gsel ? {s1_x, s1_y} : {s0_x, s0_y};
    unique case (state)
      ST_IDLE: begin
        // The grant is taken here; the first point is accepted next cycle.
        if (s0_valid && s1_valid) begin
          gsel_nx  = ~last_grant;
          state_nx = ST_FILL;
        end else if (s0_valid) begin
          gsel_nx  = 1'b0;
          state_nx = ST_FILL;
        end else if (s1_valid) begin
          gsel_nx  = 1'b1;
          state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        s0_ready = ~gsel;
        s1_ready = gsel;
        fill_hs  = gsel ? s1_valid : s0_valid;
        if (fill_hs && last_pt) begin
          state_nx = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_pt) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done pulse in the expiry cycle takes priority over the abort.
        if (eng_done) begin
          state_nx = ST_RESULT;
        end else if (wd_cnt == TOW'(TIMEOUT - 1)) begin
          expire   = 1'b1;
          state_nx = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      gsel        <= 1'b0;
      last_grant  <= 1'b1;
      pt_cnt      <= '0;
      wd_cnt      <= '0;
      eng_load    <= 1'b0;
      eng_abort   <= 1'b0;
      res_valid   <= 1'b0;
      res_src     <= 1'b0;
      res_timeout <= 1'b0;
      res_q       <= '0;
    end else begin
      state     <= state_nx;
      gsel      <= gsel_nx;
      // eng_load lags STREAM by one cycle to line up with the registered
      // buffer read of buf[pt_cnt].
      eng_load  <= (state == ST_STREAM);
      eng_abort <= expire;
      if (fill_hs || (state == ST_STREAM)) begin
        pt_cnt <= wrap_inc(pt_cnt);
      end
      wd_cnt <= (state == ST_WAIT) ? wd_cnt + TOW'(1) : '0;
      if ((state == ST_WAIT) && eng_done) begin
        res_q       <= {eng_c1x, eng_c1y, eng_c2x, eng_c2y};
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
        res_src     <= gsel;
      end else if (expire) begin
        res_q       <= '0;
        res_timeout <= 1'b1;
        res_valid   <= 1'b1;
        res_src     <= gsel;
      end
      if ((state == ST_RESULT) && res_ready) begin
        res_valid  <= 1'b0;
        last_grant <= gsel;
      end
    end
  end

  laser_pt_buf u_buf (
    .CLK    (CLK),
    .RST    (RST),
    .wr_en  (fill_hs),
    .wr_idx (pt_cnt),
    .wr_pt  (wr_pt),
    .rd_en  (state == ST_STREAM),
    .rd_idx (pt_cnt),
    .rd_pt  (rd_pt)
  );

  assign rd_s    = rd_pt;
  assign eng_x   = rd_s.x;
  assign eng_y   = rd_s.y;
  assign res_c1x = res_q.c1x;
  assign res_c1y = res_q.c1y;
  assign res_c2x = res_q.c2x;
  assign res_c2y = res_q.c2y;

endmodule

// File: tb/tb_laser_frame_sched.sv
// Bench for laser_frame_sched: directed sequence of scenarios driven from one
// initial block with randomized frame data and engine behaviour. The model
// keeps per-source frames, the expected point stream, the round-robin grant
// rule and the expected result of each frame.
module tb_laser_frame_sched;
  import laser_pkg::*;

  localparam int TMO = 600;

  logic          CLK = 1'b0;
  logic          RST;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [CW-1:0] s0_x, s0_y, s1_x, s1_y;
  logic          eng_load;
  logic [CW-1:0] eng_x, eng_y;
  logic          eng_done;
  logic [CW-1:0] eng_c1x, eng_c1y, eng_c2x, eng_c2y;
  logic          eng_abort;
  logic          res_valid, res_ready, res_src, res_timeout;
  logic [CW-1:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic [2:0]    dbg_state;

  // clock / reset block
  always #5 CLK = ~CLK;

  laser_frame_sched #(.TIMEOUT(TMO), .TOW(16)) dut (
    .CLK(CLK), .RST(RST),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_x(s0_x), .s0_y(s0_y),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_x(s1_x), .s1_y(s1_y),
    .eng_load(eng_load), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_c1x(eng_c1x), .eng_c1y(eng_c1y),
    .eng_c2x(eng_c2x), .eng_c2y(eng_c2y), .eng_abort(eng_abort),
    .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
    .res_timeout(res_timeout), .res_c1x(res_c1x), .res_c1y(res_c1y),
    .res_c2x(res_c2x), .res_c2y(res_c2y), .dbg_state(dbg_state)
  );

  // scoreboard / model state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_pts [2][NPTS];
  int         idx [2];
  int         rem [2];
  bit         gapped [2];
  logic       m_last;
  int         cyc;
  int         acc;
  bit         h;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, 32'({s0_ready, s1_ready, eng_load, eng_x, eng_y, eng_abort,
                               res_valid, res_src, res_timeout,
                               res_c1x, res_c1y, res_c2x, res_c2y}), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic gen_frame(input int s, input bit pat);
    for (int i = 0; i < NPTS; i++) begin
      src_pts[s][i] = pat ? {4'(i % 16), 4'(i / 16)} : 8'($urandom_range(0, 255));
    end
  endtask

  // Asynchronous reset applied mid-cycle; after reset S0 wins the first tie.
  task automatic do_reset(input string tag);
    RST = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
    #3;
    check_idle({tag, "_async"});
    repeat (2) @(posedge CLK);
    #1;
    check_idle({tag, "_held"});
    RST = 1'b0;
    m_last = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
  endtask

  // mode: 0 engine answers after a delay, 1 engine silent, 2 answer in the
  // watchdog expiry cycle. stall: cycles res_ready stays low per result.
  task automatic run_frames(input int n0, input int n1, input bit gap1, input bit pat,
                            input int mode, input int stall, input bit stray);
    int          total, done_n, budget, wait_start, abort_cnt, abort_cyc;
    int          cur_run, run_cnt, run_len, stall_left, dly, viol_both, viol_stab;
    bit          in_wait, have_res, stray_done, res_hs;
    bit          hs [2];
    logic        exp_src, exp_to, exp_g;
    logic [15:0] exp_c, eng_c, lat_c;
    logic [1:0]  lat_m;
    logic [7:0]  pt, exp_pt;
    rem[0] = n0;
    rem[1] = n1;
    for (int s = 0; s < 2; s++) begin
      idx[s] = 0;
      gapped[s] = 1'b0;
      if (rem[s] > 0) gen_frame(s, pat);
    end
    total = n0 + n1; done_n = 0; budget = total * (TMO + 400) + 100;
    wait_start = 0; abort_cnt = 0; abort_cyc = 0; cur_run = 0; run_cnt = 0; run_len = 0;
    stall_left = stall; viol_both = 0; viol_stab = 0; dly = 1;
    in_wait = 1'b0; have_res = 1'b0; stray_done = 1'b0; res_hs = 1'b0;
    exp_src = 1'b0; exp_to = 1'b0; exp_c = '0; eng_c = '0; lat_c = '0; lat_m = '0;
    while (done_n < total && budget > 0) begin
      budget--;
      cyc++;
      // observe this cycle
      if (s0_ready && s1_ready) viol_both++;
      if (eng_load) begin
        pt = {eng_x, eng_y};
        if (exp_q.size() > 0) begin
          exp_pt = exp_q.pop_front();
          check("stream_pt", 32'(pt), 32'(exp_pt));
        end else begin
          check("stream_extra", 32'(pt), 32'h100);
        end
        cur_run++;
      end else if (cur_run > 0) begin
        run_cnt++;
        run_len = cur_run;
        cur_run = 0;
      end
      if (dbg_state == ST_WAIT && !in_wait) begin
        in_wait = 1'b1;
        wait_start = cyc;
      end
      if (eng_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      // driver: sources
      s0_valid = (rem[0] > 0);
      {s0_x, s0_y} = src_pts[0][idx[0]];
      s1_valid = (rem[1] > 0);
      {s1_x, s1_y} = src_pts[1][idx[1]];
      if (gap1 && s1_valid && (idx[1] % 3 == 2) && !gapped[1]) begin
        s1_valid = 1'b0;
        gapped[1] = 1'b1;
      end
      // driver: engine (junk centres except in the done cycle)
      eng_done = 1'b0;
      {eng_c1x, eng_c1y, eng_c2x, eng_c2y} = 16'($urandom);
      if (in_wait && mode != 1 && (cyc - wait_start) == dly) begin
        eng_done = 1'b1;
        {eng_c1x, eng_c1y, eng_c2x, eng_c2y} = eng_c;
      end
      if (stray && !stray_done && dbg_state == ST_FILL) begin
        eng_done = 1'b1;
        stray_done = 1'b1;
      end
      // driver: result consumer
      res_ready = 1'b0;
      res_hs = 1'b0;
      if (res_valid) begin
        if (!have_res) begin
          have_res = 1'b1;
          lat_c = {res_c1x, res_c1y, res_c2x, res_c2y};
          lat_m = {res_src, res_timeout};
        end else if ({res_c1x, res_c1y, res_c2x, res_c2y} !== lat_c ||
                     {res_src, res_timeout} !== lat_m) begin
          viol_stab++;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          res_ready = 1'b1;
          res_hs = 1'b1;
          check("res_src", 32'(res_src), 32'(exp_src));
          check("res_timeout", 32'(res_timeout), 32'(exp_to));
          check("res_centres", 32'({res_c1x, res_c1y, res_c2x, res_c2y}), 32'(exp_c));
          check("abort_count", 32'(abort_cnt), exp_to ? 32'd1 : 32'd0);
          if (exp_to) check("abort_latency", 32'(abort_cyc - wait_start), 32'(TMO));
          check("load_runs", 32'(run_cnt), 32'd1);
          check("load_len", 32'(run_len), 32'(NPTS));
          check("stream_left", 32'(exp_q.size()), 32'd0);
          check("both_ready", 32'(viol_both), 32'd0);
          check("res_stable", 32'(viol_stab), 32'd0);
        end
      end
      hs[0] = s0_valid && s0_ready;
      hs[1] = s1_valid && s1_ready;
      @(posedge CLK);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (hs[s]) begin
          gapped[s] = 1'b0;
          idx[s]++;
          if (idx[s] == NPTS) begin
            exp_g = (rem[0] > 0 && rem[1] > 0) ? ~m_last : ((rem[0] > 0) ? 1'b0 : 1'b1);
            check("grant", 32'(s), 32'(exp_g));
            exp_src = exp_g;
            for (int i = 0; i < NPTS; i++) exp_q.push_back(src_pts[s][i]);
            rem[s]--;
            idx[s] = 0;
            if (rem[s] > 0) gen_frame(s, pat);
            exp_to = (mode == 1);
            eng_c  = pat ? 16'h34B9 : 16'($urandom);
            exp_c  = exp_to ? 16'h0000 : eng_c;
            dly    = (mode == 2) ? TMO - 1 : (pat ? 100 : int'($urandom_range(1, 40)));
          end
        end
      end
      if (res_hs) begin
        done_n++;
        m_last = exp_src;
        in_wait = 1'b0; have_res = 1'b0; abort_cnt = 0; run_cnt = 0; run_len = 0;
        stall_left = stall; viol_both = 0; viol_stab = 0;
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
    check("frames_done", 32'(done_n), 32'(total));
  endtask

  initial begin
    RST = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_x = '0; s0_y = '0; s1_x = '0; s1_y = '0;
    eng_done = 1'b0; eng_c1x = '0; eng_c1y = '0; eng_c2x = '0; eng_c2y = '0;
    res_ready = 1'b0; cyc = 0; m_last = 1'b1; acc = 0; h = 1'b0;
    do_reset("por");
    // 1: S0 pattern frame, engine answers 100 cycles after the last load
    run_frames(1, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    // 2: both sources contend from reset, 3 frames each
    do_reset("contend");
    run_frames(3, 3, 1'b0, 1'b0, 0, 0, 1'b0);
    // 3: S1 with a valid gap before every third point
    run_frames(0, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    // 4: silent engine, watchdog abort
    run_frames(1, 0, 1'b0, 1'b0, 1, 0, 1'b0);
    // 5: done in the expiry cycle, stray done during FILL
    run_frames(0, 1, 1'b0, 1'b0, 2, 0, 1'b1);
    // 6: stalled result consumer, then reset in the middle of a fill
    run_frames(1, 0, 1'b0, 1'b0, 0, 50, 1'b0);
    for (int k = 0; k < 100 && acc < 10; k++) begin
      s1_valid = 1'b1;
      {s1_x, s1_y} = 8'($urandom);
      h = s1_ready;
      @(posedge CLK);
      #1;
      if (h) acc++;
    end
    check("midfill_accepted", 32'(acc), 32'd10);
    do_reset("midfill");
    run_frames(1, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
